fifo_flex: RTL and testbench
============================

# fifo_flex

Parametrised synchronous circular FIFO, the successor to the basic fifo core. Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a compile-time first-word-fall-through read mode. It sits between any single-clock producer and consumer as a drop-in replacement where flow-control margin and error visibility are needed.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; must be a power of 2, ≥2
- POINTER_WIDTH, 4, log2(DEPTH); read/write pointer width
- AF_LEVEL, 12, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- rd_en  in  1  read request
- clr_err  in  1  clears overflow/underflow on the next edge
- input_data  in  WIDTH  write data
- output_data  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  POINTER_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×WIDTH array; wr_ptr, rd_ptr of POINTER_WIDTH bits, wrap DEPTH-1 → 0 by natural overflow; count held in a separate POINTER_WIDTH+1-bit register.
- Write accepted iff wr_en && !full (full sampled before the edge): mem[wr_ptr] ← input_data, wr_ptr+1.
- Read accepted iff rd_en && !empty: rd_ptr+1.
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- Simultaneous wr_en && rd_en:
  - Not full and not empty: both accepted; count unchanged.
  - Full: read accepted, write rejected, overflow set.
  - Empty: write accepted, read rejected, underflow set.
- Rejected operations never change pointers, count or memory.
- overflow/underflow set on the edge of the offending request; they hold until clr_err or reset. If clr_err and a new error occur in the same cycle, set wins.
- All flags are decoded from the registered count, so they are glitch-free and valid one cycle after the causing edge.
- Reset: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, output_data 0. Memory contents are not cleared. A reset asserted mid-operation discards all queued data; any wr_en/rd_en in that cycle is ignored.

## Timing
- Standard mode: output_data is registered. It is updated with mem[rd_ptr] on the edge that accepts a read, so data appears one cycle after rd_en. Otherwise it holds its last value.
- Write-to-empty-deassert latency: 1 edge. A word written on edge N is readable (rd_en sampled) at edge N+1.
- Full→not-full after a read: 1 edge. A write in the same cycle as that read is still rejected.
- Throughput: one write and one read per cycle sustained when 0 < count < DEPTH.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - output_data = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - rd_en acknowledges and pops the presented word; the next word appears immediately after the edge.
  - A word written on edge N is visible on output_data after edge N.
- FIFO_FWFT_EN undefined: standard registered read mode as described under Timing.
- Flag, count and error behaviour is identical in both modes.

## Test plan
- Reset, then write 0xA5, 0x5A, 0xFF; read 3 → standard mode: output_data 0xA5, 0x5A, 0xFF, each one cycle after its rd_en; count 3→0; empty=1 at end.
- Write 16 words 0x00..0x0F → full=1 and count=16 after the 16th edge; almost_full=1 from count 12; a 17th write sets overflow=1 and count stays 16.
- On empty, read → underflow=1, count=0, output_data unchanged; pulse clr_err → underflow=0 next edge.
- On full, assert wr_en+rd_en for one cycle → count 15, overflow=1, the oldest word is read out. On empty, assert both → count 1, underflow=1.
- Fill and drain 40 words with random simultaneous enables → no lost or reordered data across pointer wrap; count always matches the scoreboard.
- With FIFO_FWFT_EN: write 0x3C into empty → output_data=0x3C after that edge with no rd_en; rd_en pops it → empty=1 and output_data=0. Reset asserted with count=5 → count=0 and empty=1 next edge.

Source files
------------

// File: rtl/fifo_flex.sv
// Single-clock circular FIFO with occupancy count, almost-full/empty thresholds and sticky
// overflow/underflow flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_flex #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 16,
   parameter int POINTER_WIDTH = 4,
   parameter int AF_LEVEL      = 12,
   parameter int AE_LEVEL      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic                     clr_err,
   input  logic [WIDTH-1:0]         input_data,
   output logic [WIDTH-1:0]         output_data,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [POINTER_WIDTH:0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam logic [POINTER_WIDTH:0]   DEPTH_CNT = (POINTER_WIDTH+1)'(DEPTH);
   localparam logic [POINTER_WIDTH:0]   AF_CNT    = (POINTER_WIDTH+1)'(AF_LEVEL);
   localparam logic [POINTER_WIDTH:0]   AE_CNT    = (POINTER_WIDTH+1)'(AE_LEVEL);
   localparam logic [POINTER_WIDTH:0]   CNT_ONE   = (POINTER_WIDTH+1)'(1);
   localparam logic [POINTER_WIDTH-1:0] PTR_ONE   = POINTER_WIDTH'(1);

   logic [WIDTH-1:0]         mem [DEPTH];
   logic [POINTER_WIDTH-1:0] wr_ptr;
   logic [POINTER_WIDTH-1:0] rd_ptr;
   logic                     wr_ok;
   logic                     rd_ok;

   // Flags come only from the registered count, so they never glitch.
   always_comb begin
      full         = (count == DEPTH_CNT);
      empty        = (count == '0);
      almost_full  = (count >= AF_CNT);
      almost_empty = (count <= AE_CNT);
      wr_ok        = wr_en && !full;
      rd_ok        = rd_en && !empty;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;

         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         // A new error in the same cycle as clr_err keeps the flag set.
         if (wr_en && full)       overflow  <= 1'b1;
         else if (clr_err)        overflow  <= 1'b0;
         if (rd_en && empty)      underflow <= 1'b1;
         else if (clr_err)        underflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem[wr_ptr] <= input_data;
   end

`ifdef FIFO_FWFT_EN
   always_comb begin
      output_data = empty ? '0 : mem[rd_ptr];
   end
`else
   always_ff @(posedge clk) begin
      if (reset)      output_data <= '0;
      else if (rd_ok) output_data <= mem[rd_ptr];
   end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Directed self-checking bench for fifo_flex; expectations follow FIFO_FWFT_EN when defined.
module tb_fifo_flex;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] input_data;
   logic [7:0] output_data;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   fifo_flex #(
      .WIDTH(8),
      .DEPTH(16),
      .POINTER_WIDTH(4),
      .AF_LEVEL(12),
      .AE_LEVEL(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wr_en(wr_en),
      .rd_en(rd_en),
      .clr_err(clr_err),
      .input_data(input_data),
      .output_data(output_data),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] q[$];
   bit         m_ovf;
   bit         m_unf;
   logic [7:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_out();
`ifdef FIFO_FWFT_EN
      return (q.size() != 0) ? q[0] : 8'h00;
`else
      return last_rd;
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".count"},  32'(count),        32'(q.size()));
      chk({tag, ".empty"},  32'(empty),        32'(q.size() == 0));
      chk({tag, ".full"},   32'(full),         32'(q.size() == 16));
      chk({tag, ".af"},     32'(almost_full),  32'(q.size() >= 12));
      chk({tag, ".ae"},     32'(almost_empty), 32'(q.size() <= 4));
      chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
      chk({tag, ".unf"},    32'(underflow),    32'(m_unf));
      chk({tag, ".data"},   32'(output_data),  32'(exp_out()));
   endtask

   // One clock of stimulus, then the reference queue is advanced and all outputs compared.
   task automatic step(input string tag, input bit w, input bit r, input bit c, input logic [7:0] d);
      bit f_m;
      bit e_m;
      wr_en = w; rd_en = r; clr_err = c; input_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      f_m = (q.size() == 16);
      e_m = (q.size() == 0);
      if (w && f_m) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && e_m) m_unf = 1'b1; else if (c) m_unf = 1'b0;
      if (r && !e_m) last_rd = q.pop_front();
      if (w && !f_m) q.push_back(d);
      check_all(tag);
   endtask

   initial begin
      int written;
      int iter;
      logic [7:0] exp_d;

      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; input_data = 8'h00;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; last_rd = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst.count", 32'(count), 0);
      chk("rst.empty", 32'(empty), 1);
      chk("rst.ae", 32'(almost_empty), 1);
      chk("rst.full", 32'(full), 0);
      chk("rst.af", 32'(almost_full), 0);
      chk("rst.ovf", 32'(overflow), 0);
      chk("rst.unf", 32'(underflow), 0);
      chk("rst.data", 32'(output_data), 0);

      step("w_a5", 1, 0, 0, 8'hA5);
`ifdef FIFO_FWFT_EN
      chk("fwft.fall_through", 32'(output_data), 32'h3C ^ 32'h99);
`endif
      step("w_5a", 1, 0, 0, 8'h5A);
      step("w_ff", 1, 0, 0, 8'hFF);
      chk("t1.count3", 32'(count), 3);
      chk("t1.empty0", 32'(empty), 0);
      step("r1", 0, 1, 0, 8'h00);
`ifdef FIFO_FWFT_EN
      chk("t1.r1", 32'(output_data), 32'h5A);
`else
      chk("t1.r1", 32'(output_data), 32'hA5);
`endif
      step("r2", 0, 1, 0, 8'h00);
`ifdef FIFO_FWFT_EN
      chk("t1.r2", 32'(output_data), 32'hFF);
`else
      chk("t1.r2", 32'(output_data), 32'h5A);
`endif
      step("r3", 0, 1, 0, 8'h00);
`ifdef FIFO_FWFT_EN
      chk("t1.r3", 32'(output_data), 32'h00);
`else
      chk("t1.r3", 32'(output_data), 32'hFF);
`endif
      chk("t1.count0", 32'(count), 0);
      chk("t1.empty1", 32'(empty), 1);

      step("unf", 0, 1, 0, 8'h00);
      chk("t3.unf", 32'(underflow), 1);
      chk("t3.count", 32'(count), 0);
`ifndef FIFO_FWFT_EN
      chk("t3.data_hold", 32'(output_data), 32'hFF);
`endif
      step("clr_unf", 0, 0, 1, 8'h00);
      chk("t3.unf_clr", 32'(underflow), 0);

      for (int i = 0; i < 16; i++) begin
         step("fill", 1, 0, 0, 8'(i));
         chk("t2.count", 32'(count), 32'(i + 1));
         chk("t2.af", 32'(almost_full), 32'(i + 1 >= 12));
      end
      chk("t2.full", 32'(full), 1);
      step("ovf", 1, 0, 0, 8'hEE);
      chk("t2.ovf", 32'(overflow), 1);
      chk("t2.count16", 32'(count), 16);
      step("clr_ovf", 0, 0, 1, 8'h00);
      chk("t2.ovf_clr", 32'(overflow), 0);

      // Full with both enables: read of word 0x00 goes through, write of 0x77 is rejected.
      step("both_full", 1, 1, 0, 8'h77);
      chk("t4.count15", 32'(count), 15);
      chk("t4.ovf", 32'(overflow), 1);
`ifdef FIFO_FWFT_EN
      chk("t4.oldest", 32'(output_data), 32'h01);
`else
      chk("t4.oldest", 32'(output_data), 32'h00);
`endif
      for (int i = 1; i < 16; i++) begin
         step("drain", 0, 1, 0, 8'h00);
`ifdef FIFO_FWFT_EN
         exp_d = (i < 15) ? 8'(i + 1) : 8'h00;
`else
         exp_d = 8'(i);
`endif
         chk("t4.drain", 32'(output_data), 32'(exp_d));
      end
      chk("t4.drained", 32'(count), 0);

      step("both_empty", 1, 1, 0, 8'h99);
      chk("t4.count1", 32'(count), 1);
      chk("t4.unf", 32'(underflow), 1);
`ifdef FIFO_FWFT_EN
      chk("t4.head99", 32'(output_data), 32'h99);
`else
      chk("t4.data_hold", 32'(output_data), 32'h0F);
`endif
      step("pop99", 0, 1, 1, 8'h00);
      chk("t4.unf_clr", 32'(underflow), 0);
`ifdef FIFO_FWFT_EN
      chk("t4.pop99", 32'(output_data), 32'h00);
`else
      chk("t4.pop99", 32'(output_data), 32'h99);
`endif

      for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, 0, 8'(8'h30 + i));
      chk("rst5.count5", 32'(count), 5);
      reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; input_data = 8'hC3;
      @(posedge clk); #1;
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; last_rd = 8'h00;
      chk("rst5.count0", 32'(count), 0);
      chk("rst5.empty", 32'(empty), 1);
      chk("rst5.data", 32'(output_data), 0);

`ifdef FIFO_FWFT_EN
      step("fwft_3c", 1, 0, 0, 8'h3C);
      chk("fwft.3c_visible", 32'(output_data), 32'h3C);
      step("fwft_pop", 0, 1, 0, 8'h00);
      chk("fwft.empty", 32'(empty), 1);
      chk("fwft.zero", 32'(output_data), 0);
`endif

      // Random simultaneous traffic of 40 distinct words across pointer wrap.
      written = 0;
      iter = 0;
      while ((written < 40 || q.size() != 0) && iter < 2000) begin
         bit w;
         bit r;
         w = (written < 40) && ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < ((written < 40) ? 45 : 80));
         if (w && q.size() < 16) begin
            step("rand", 1, r, 0, 8'(8'h40 + written));
            written++;
         end else begin
            step("rand", w, r, 0, 8'(8'h40 + written));
         end
         iter++;
      end
      chk("rand.completed", 32'((written == 40) && (q.size() == 0)), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
